// File: rtl/spike_pkg.sv
// spike_pkg: state type and width helpers shared by the spike vector player
package spike_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} player_state_t;

    // t_stamp width: enough bits to count 0..len-1
    function automatic int ts_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // spike_cnt width: enough bits to hold a popcount of 0..len
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

    // gap counter width: at least one bit even when no gap is configured
    function automatic int gap_w(input int gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/spike_hold_buf.sv
// spike_hold_buf: single-entry holding register for one pending spike vector
//   clk, rst : clock, asynchronous active-high reset
//   i_wr     : capture i_data and mark the entry full
//   i_pop    : release the entry (mark empty)
//   i_data   : vector to capture
//   o_full   : entry holds a pending vector
//   o_data   : pending vector
module spike_hold_buf #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_wr,
    input  logic           i_pop,
    input  logic [0:LEN-1] i_data,
    output logic           o_full,
    output logic [0:LEN-1] o_data
);

    logic           r_full;
    logic [0:LEN-1] r_data;

    assign o_full = r_full;
    assign o_data = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/spike_vec_player.sv
// spike_vec_player: replays a LEN-bit spike vector serially, one time stamp per clock
//   clk, rst  : clock, asynchronous active-high reset
//   in_vec    : spike vector, bit 0 is t=0
//   in_valid  : in_vec valid
//   in_ready  : a vector can be accepted this cycle (hold buffer empty)
//   spike_out : serial spike for the current time stamp
//   t_stamp   : current time stamp within the window
//   win_start : t=0 cycle of a window
//   done      : t=LEN-1 cycle of a window
//   busy      : playing a window or inside the inter-window gap
//   spike_cnt : popcount of the last completed window (only with SPIKE_CNT_EN)
module spike_vec_player
    import spike_pkg::*;
#(
    parameter int LEN       = 8,
    parameter int GAMMA_GAP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:LEN-1]        in_vec,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  spike_out,
    output logic [ts_w(LEN)-1:0]  t_stamp,
    output logic                  win_start,
    output logic                  done,
    output logic                  busy
`ifdef SPIKE_CNT_EN
    ,
    output logic [cnt_w(LEN)-1:0] spike_cnt
`endif
);

    localparam int TW    = ts_w(LEN);
    localparam int GW    = gap_w(GAMMA_GAP);
    localparam int GLAST = (GAMMA_GAP > 0) ? GAMMA_GAP - 1 : 0;

    player_state_t  r_state;
    logic [0:LEN-1] r_sh;
    logic [TW-1:0]  r_t;
    logic [GW-1:0]  r_gap;
    logic           r_spike, r_win, r_done, r_busy;
    logic           w_full, w_xfer, w_last, w_load_pt, w_load, w_wr, w_pop;
    logic [0:LEN-1] w_held, w_next;

    assign in_ready  = !w_full;
    assign spike_out = r_spike;
    assign t_stamp   = r_t;
    assign win_start = r_win;
    assign done      = r_done;
    assign busy      = r_busy;

    assign w_xfer    = in_valid && in_ready;
    assign w_last    = (r_t == TW'(LEN - 1));
    assign w_load_pt = (r_state == IDLE) ||
                       (r_state == PLAY && w_last && GAMMA_GAP == 0) ||
                       (r_state == GAP && r_gap == GW'(GLAST));
    assign w_load    = w_load_pt && (w_full || w_xfer);
    // a held vector always has priority; otherwise the incoming vector bypasses the buffer
    assign w_next    = w_full ? w_held : in_vec;
    assign w_pop     = w_load_pt && w_full;
    // a transfer is only possible with an empty buffer, so at a load point it is consumed directly
    assign w_wr      = w_xfer && !w_load_pt;

    spike_hold_buf #(.LEN(LEN)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_wr   (w_wr),
        .i_pop  (w_pop),
        .i_data (in_vec),
        .o_full (w_full),
        .o_data (w_held)
    );

    // r_sh holds the bits still to be played, next bit at index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_t     <= '0;
            r_gap   <= '0;
            r_spike <= 1'b0;
            r_win   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_win  <= 1'b0;
            r_done <= 1'b0;
            if (w_load) begin
                r_state <= PLAY;
                r_sh    <= {w_next[1:LEN-1], 1'b0};
                r_spike <= w_next[0];
                r_t     <= '0;
                r_win   <= 1'b1;
                r_busy  <= 1'b1;
            end else if (r_state == PLAY && !w_last) begin
                r_sh    <= {r_sh[1:LEN-1], 1'b0};
                r_spike <= r_sh[0];
                r_t     <= r_t + TW'(1);
                r_done  <= (r_t == TW'(LEN - 2));
            end else if (r_state == PLAY && GAMMA_GAP > 0) begin
                r_state <= GAP;
                r_gap   <= '0;
                r_spike <= 1'b0;
                r_t     <= '0;
            end else if (r_state == GAP && r_gap != GW'(GLAST)) begin
                r_gap   <= r_gap + GW'(1);
            end else begin
                r_state <= IDLE;
                r_spike <= 1'b0;
                r_t     <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

`ifdef SPIKE_CNT_EN
    localparam int CW = cnt_w(LEN);

    logic [CW-1:0] w_pop_cnt, r_cur_cnt, r_cnt;

    assign spike_cnt = r_cnt;

    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < LEN; i++) w_pop_cnt = w_pop_cnt + CW'(w_next[i]);
    end

    // the window's count is captured at load and published when its last cycle ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_cnt <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_load) r_cur_cnt <= w_pop_cnt;
            if (r_state == PLAY && w_last) r_cnt <= r_cur_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_spike_vec_player.sv
// tb_spike_vec_player: randomized self-checking bench with a window/queue reference model
module tb_spike_vec_player;

    localparam int LEN = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [0:LEN-1] vec0 = '0, vec1 = '0;
    logic           val0 = 1'b0, val1 = 1'b0;
    logic           rdy0, rdy1, sp0, sp1, ws0, ws1, dn0, dn1, bz0, bz1;
    logic [2:0]     ts0, ts1;
    logic [3:0]     cn0, cn1;
    logic [11:0]    ob0, ob1;
    int             tests = 0;
    int             fails = 0;

    int             m_pos[2];
    logic [0:LEN-1] m_cur[2], m_pv[2];
    logic           m_pf[2], m_xfer[2];
    logic [3:0]     m_cnt[2];

    always #5 clk = ~clk;

    spike_vec_player #(.LEN(LEN), .GAMMA_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_vec(vec0), .in_valid(val0), .in_ready(rdy0),
        .spike_out(sp0), .t_stamp(ts0), .win_start(ws0), .done(dn0), .busy(bz0)
`ifdef SPIKE_CNT_EN
        , .spike_cnt(cn0)
`endif
    );

    spike_vec_player #(.LEN(LEN), .GAMMA_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .in_vec(vec1), .in_valid(val1), .in_ready(rdy1),
        .spike_out(sp1), .t_stamp(ts1), .win_start(ws1), .done(dn1), .busy(bz1)
`ifdef SPIKE_CNT_EN
        , .spike_cnt(cn1)
`endif
    );

`ifndef SPIKE_CNT_EN
    assign cn0 = 4'd0;
    assign cn1 = 4'd0;
`endif

    assign ob0 = {rdy0, sp0, ts0, ws0, dn0, bz0, cn0};
    assign ob1 = {rdy1, sp1, ts1, ws1, dn1, bz1, cn1};

    // model: m_pos is the position within window+gap, -1 when idle; m_pf marks a pending vector
    task automatic model_reset(input int d);
        m_pos[d]  = -1;
        m_cur[d]  = '0;
        m_pv[d]   = '0;
        m_pf[d]   = 1'b0;
        m_xfer[d] = 1'b0;
        m_cnt[d]  = 4'd0;
    endtask

    task automatic model_edge(input int d, input logic v, input logic [0:LEN-1] vec, input int gap);
        if (rst) begin
            model_reset(d);
            return;
        end
        m_xfer[d] = v && !m_pf[d];
        if (m_xfer[d]) begin
            m_pf[d] = 1'b1;
            m_pv[d] = vec;
        end
        if (m_pos[d] == LEN - 1) m_cnt[d] = 4'($countones(m_cur[d]));
        if (m_pos[d] < 0 || m_pos[d] == LEN + gap - 1) begin
            if (m_pf[d]) begin
                m_cur[d] = m_pv[d];
                m_pf[d]  = 1'b0;
                m_pos[d] = 0;
            end else begin
                m_pos[d] = -1;
            end
        end else begin
            m_pos[d]++;
        end
    endtask

    function automatic logic [11:0] exp_b(input int d);
        int             p;
        logic           pl;
        logic [0:LEN-1] v;
        logic [3:0]     c;
        p  = m_pos[d];
        pl = (p >= 0) && (p < LEN);
        v  = m_cur[d];
`ifdef SPIKE_CNT_EN
        c = m_cnt[d];
`else
        c = 4'd0;
`endif
        return {!m_pf[d], pl ? v[pl ? p : 0] : 1'b0, pl ? 3'(p) : 3'd0,
                p == 0, p == LEN - 1, p >= 0, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0, val0, vec0, 0);
        model_edge(1, val1, vec1, 2);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (ob0 !== 12'h800) begin
            fails++;
            $display("FAIL reset0 got %b want %b", ob0, 12'h800);
        end
        tests++;
        if (ob1 !== 12'h800) begin
            fails++;
            $display("FAIL reset1 got %b want %b", ob1, 12'h800);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [0:LEN-1] seen;
        seen = '0;
        vec0 = 8'b0100_0000;
        val0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (m_xfer[0]) val0 = 1'b0;
            tests++;
            if (ob0 !== exp_b(0)) begin
                fails++;
                $display("FAIL single cyc%0d got %b want %b", c, ob0, exp_b(0));
            end
            if (sp0) seen[ts0] = 1'b1;
        end
        tests++;
        if (seen !== 8'b0100_0000 || bz0 !== 1'b0) begin
            fails++;
            $display("FAIL single_pos got seen=%b busy=%b want seen=01000000 busy=0", seen, bz0);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:15] st;
        logic [0:15] want;
        bit          saw_stall;
        bit          idle_gap;
        int          n;
        st = '0;
        want = 16'b0110_0011_1000_0001;
        saw_stall = 0;
        idle_gap = 0;
        n = 0;
        vec0 = 8'b0110_0011;
        val0 = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (m_xfer[0]) begin
                n++;
                if (n == 1) vec0 = 8'b1000_0001;
                else val0 = 1'b0;
            end
            tests++;
            if (ob0 !== exp_b(0)) begin
                fails++;
                $display("FAIL b2b cyc%0d got %b want %b", c, ob0, exp_b(0));
            end
            if (c < 16) begin
                st[c] = sp0;
                if (!bz0) idle_gap = 1;
            end
            if (!rdy0) saw_stall = 1;
        end
        tests++;
        if (st !== want || !saw_stall || idle_gap) begin
            fails++;
            $display("FAIL b2b_stream got %b stall=%0d idle=%0d want %b stall=1 idle=0",
                     st, saw_stall, idle_gap, want);
        end
    endtask

    task automatic test_gap();
        bit measuring;
        bit measured;
        int gapcnt;
        int n;
        measuring = 0;
        measured = 0;
        gapcnt = 0;
        n = 0;
        vec1 = LEN'($urandom);
        val1 = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (m_xfer[1]) begin
                n++;
                if (n == 1) vec1 = LEN'($urandom);
                else val1 = 1'b0;
            end
            tests++;
            if (ob1 !== exp_b(1)) begin
                fails++;
                $display("FAIL gap cyc%0d got %b want %b", c, ob1, exp_b(1));
            end
            if (measuring && ws1) begin
                measuring = 0;
                measured = 1;
            end else if (measuring && !sp1 && bz1) begin
                gapcnt++;
            end
            if (dn1 && !measured) measuring = 1;
        end
        tests++;
        if (gapcnt != 2 || !measured) begin
            fails++;
            $display("FAIL gap_len got %0d measured=%0d want 2 measured=1", gapcnt, measured);
        end
    endtask

    task automatic test_zero();
        int nbusy;
        int nws;
        int ndn;
        nbusy = 0;
        nws = 0;
        ndn = 0;
        vec0 = '0;
        val0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (m_xfer[0]) val0 = 1'b0;
            tests++;
            if (ob0 !== exp_b(0)) begin
                fails++;
                $display("FAIL zero cyc%0d got %b want %b", c, ob0, exp_b(0));
            end
            if (bz0 && !sp0) nbusy++;
            if (ws0) nws++;
            if (dn0) ndn++;
        end
        tests++;
        if (nbusy != 8 || nws != 1 || ndn != 1) begin
            fails++;
            $display("FAIL zero_win got busy=%0d ws=%0d done=%0d want 8 1 1", nbusy, nws, ndn);
        end
    endtask

    task automatic test_reset_mid();
        logic [0:LEN-1] c_vec;
        bit             hit;
        int             n;
        hit = 0;
        n = 0;
        vec0 = LEN'($urandom);
        val0 = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (m_xfer[0]) begin
                n++;
                if (n == 1) vec0 = LEN'($urandom);
                else val0 = 1'b0;
            end
            if (ts0 == 3'd4 && bz0) hit = 1;
        end
        tests++;
        if (!hit || ob0 !== exp_b(0) || rdy0 !== 1'b0) begin
            fails++;
            $display("FAIL rmid_pre got %b hit=%0d want %b", ob0, hit, exp_b(0));
        end
        val0 = 1'b0;
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        tests++;
        if (ob0 !== 12'h800) begin
            fails++;
            $display("FAIL rmid_async got %b want %b", ob0, 12'h800);
        end
        #2;
        rst = 1'b0;
        c_vec = LEN'($urandom);
        vec0 = c_vec;
        val0 = 1'b1;
        tick();
        val0 = 1'b0;
        tests++;
        if (ts0 !== 3'd0 || ws0 !== 1'b1 || sp0 !== c_vec[0] || ob0 !== exp_b(0)) begin
            fails++;
            $display("FAIL rmid_restart got %b want %b", ob0, exp_b(0));
        end
        for (int c = 0; c < 9; c++) begin
            tick();
            tests++;
            if (ob0 !== exp_b(0)) begin
                fails++;
                $display("FAIL rmid_play cyc%0d got %b want %b", c, ob0, exp_b(0));
            end
        end
    endtask

`ifdef SPIKE_CNT_EN
    task automatic test_spike_cnt();
        int n;
        n = 0;
        vec0 = 8'b1111_0001;
        val0 = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (m_xfer[0]) begin
                n++;
                if (n == 1) vec0 = '0;
                else val0 = 1'b0;
            end
            tests++;
            if (ob0 !== exp_b(0)) begin
                fails++;
                $display("FAIL cnt cyc%0d got %b want %b", c, ob0, exp_b(0));
            end
            if (c == 8 || c == 15) begin
                tests++;
                if (cn0 !== 4'd5) begin
                    fails++;
                    $display("FAIL cnt_hold cyc%0d got %0d want 5", c, cn0);
                end
            end
            if (c == 16) begin
                tests++;
                if (cn0 !== 4'd0) begin
                    fails++;
                    $display("FAIL cnt_zero got %0d want 0", cn0);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            val0 = (c < 380) ? 1'($urandom) : 1'b0;
            val1 = (c < 380) ? 1'($urandom) : 1'b0;
            vec0 = LEN'($urandom);
            vec1 = LEN'($urandom);
            tick();
            tests++;
            if (ob0 !== exp_b(0)) begin
                fails++;
                $display("FAIL rand0 cyc%0d got %b want %b", c, ob0, exp_b(0));
            end
            tests++;
            if (ob1 !== exp_b(1)) begin
                fails++;
                $display("FAIL rand1 cyc%0d got %b want %b", c, ob1, exp_b(1));
            end
        end
        val0 = 1'b0;
        val1 = 1'b0;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_zero();
        test_reset_mid();
`ifdef SPIKE_CNT_EN
        test_spike_cnt();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spike_vec_player.md
Name: spike_vec_player

Overview:
- Transmitter counterpart to the one-hot temporal shifter datapath: takes a LEN-bit spike vector (bit k = spike at time stamp t=k; unions allowed) and replays it serially on a single spike line, one time stamp per clock.
- Sits after the shifter/column logic and drives downstream serial spike consumers.
- Buffers one pending vector so consecutive windows play back-to-back.

Parameters:
- LEN, 8: window length in time stamps; vector width; must be >= 2.
- GAMMA_GAP, 0: idle cycles inserted between consecutive windows; must be >= 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_vec  input  [0:LEN-1]  spike vector; bit 0 is t=0.
- in_valid  input  1  in_vec valid.
- in_ready  output  1  block can accept in_vec this cycle.
- spike_out  output  1  serial spike for the current time stamp.
- t_stamp  output  $clog2(LEN)  current time stamp within the window.
- win_start  output  1  high during the t=0 cycle of each window.
- done  output  1  high during the t=LEN-1 cycle of each window.
- busy  output  1  high in PLAY or GAP.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- All outputs except in_ready are registered. On reset: state=IDLE, hold buffer empty, spike_out=0, t_stamp=0, win_start=0, done=0, busy=0, in_ready=1.
- A reset asserted mid-window aborts the window immediately and discards both the playing vector and the held vector.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_ready = !hold_full, combinational from state only, never from in_valid.
- Player load point: the edge where the state is IDLE, or PLAY with t_stamp==LEN-1 and GAMMA_GAP==0, or the last GAP cycle.
  - At a load point, the player loads from the hold buffer if it is full. Otherwise it loads an accepted in_vec directly (bypass).
  - Any transfer not consumed by the player is written to the hold buffer.
- Latency: a transfer at edge E into an idle, empty block gives spike_out=in_vec[0], t_stamp=0, win_start=1 after E. Bit k appears after edge E+k.
- States:
  - IDLE: spike_out=0, busy=0. Goes to PLAY on load.
  - PLAY: t_stamp increments 0..LEN-1; spike_out=vec[t_stamp]; done=1 when t_stamp==LEN-1.
    - At the last cycle: GAMMA_GAP>0 -> GAP.
    - At the last cycle with GAMMA_GAP==0: PLAY again at t=0 if a vector is available, else IDLE.
  - GAP: GAMMA_GAP cycles with spike_out=0, t_stamp=0, busy=1. Then PLAY if a vector is available, else IDLE.
- An all-zero vector still plays a full LEN-cycle window, so the time base is preserved.
- Union vectors emit a spike on every set bit.
- A simultaneous transfer and load with a full hold buffer cannot occur (in_ready=0). With an empty hold buffer, bypass applies.
- t_stamp wraps LEN-1 -> 0 only through a new load, never by free-running.

Optional Feature:
- Macro: SPIKE_CNT_EN.
- When defined: adds output spike_cnt, width $clog2(LEN+1).
  - Updated at the edge ending each window's t=LEN-1 cycle, with the popcount of the window just played.
  - Holds that value until the next window ends. Reset value 0. Cleared by a mid-window reset.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package spike_pkg:
  - Enum player_state_t {IDLE, PLAY, GAP}.
  - Width constants/functions for t_stamp and spike_cnt derived from LEN.
- One sub-module: spike_hold_buf, a single-entry LEN-bit holding register providing full flag, write and pop.

Test Plan:
- LEN=8, GAMMA_GAP=0: send in_vec=8'b0100_0000 (t=1) to an idle block -> spike_out=1 only at t_stamp=1; win_start at t=0; done at t=7; then IDLE, busy=0.
- Union 8'b0110_0011 followed by 8'b1000_0001 held valid -> spikes at t=1,2,6,7 then t=0,7 of the second window, with no idle cycle between windows. in_ready drops while the buffer is full.
- GAMMA_GAP=2, two back-to-back vectors -> exactly 2 cycles with spike_out=0 and busy=1 between the done and win_start pulses.
- All-zero vector -> 8 cycles of busy=1 with spike_out=0; win_start and done still pulse.
- Reset asserted at t_stamp=4 with the hold buffer full -> outputs go to reset values immediately, hold buffer empty, in_ready=1; the next vector plays from t=0.
- SPIKE_CNT_EN defined, vector 8'b1111_0001 -> spike_cnt=5 after the window ends; it stays 5 through a following all-zero window until that window ends, then becomes 0.
